// File: rtl/psum_accumulator.sv
// Accumulates signed PE row sums across K tiles, then rounds, shifts and saturates the total
// into a one-entry valid/ready output buffer.
module psum_accumulator #(
   parameter int unsigned PARTIAL_SUM_BW = 20,
   parameter int unsigned ACC_BW         = 24,
   parameter int unsigned OUT_BW         = 8,
   parameter int unsigned SHIFT_BW       = 5,
   parameter int unsigned BEAT_CNT_BW    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PARTIAL_SUM_BW-1:0] in_data,
   input  logic                      in_last,
   input  logic [SHIFT_BW-1:0]       shift,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_BW-1:0]         out_data,
   output logic [BEAT_CNT_BW-1:0]    beat_cnt,
   output logic                      ovf_flag,
   input  logic                      clr_flag
);

   // Wide enough that the rounding constant for the largest shift never overflows.
   localparam int unsigned RW = ACC_BW + (1 << SHIFT_BW) + 1;

   logic [ACC_BW-1:0]      acc_q, acc_d;
   logic                   first_q, first_d;
   logic [BEAT_CNT_BW-1:0] cnt_q, cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic [OUT_BW-1:0]      out_data_q, out_data_d;
   logic                   ovf_q, ovf_d;

   logic                   accept;
   logic [ACC_BW:0]        sx_w, acc_w, sum_w;
   logic                   acc_ovf;
   logic [ACC_BW-1:0]      sum_sat;
   logic signed [RW-1:0]   q_ext, q_rnd, q_sum, q_shr;
   logic [RW-OUT_BW:0]     q_hi;
   logic                   q_ovf;
   logic [OUT_BW-1:0]      q_sat;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      sx_w    = {{(ACC_BW + 1 - PARTIAL_SUM_BW){in_data[PARTIAL_SUM_BW-1]}}, in_data};
      acc_w   = {acc_q[ACC_BW-1], acc_q};
      sum_w   = first_q ? sx_w : acc_w + sx_w;
      acc_ovf = sum_w[ACC_BW] ^ sum_w[ACC_BW-1];
      if (acc_ovf) begin
         sum_sat = sum_w[ACC_BW] ? {1'b1, {(ACC_BW-1){1'b0}}} : {1'b0, {(ACC_BW-1){1'b1}}};
      end else begin
         sum_sat = sum_w[ACC_BW-1:0];
      end
   end

   // Round half toward +inf, arithmetic shift, then clamp to the output range.
   always_comb begin
      q_ext = {{(RW - ACC_BW){sum_sat[ACC_BW-1]}}, sum_sat};
      if (shift == '0) begin
         q_rnd = '0;
      end else begin
         q_rnd = RW'(1) << (shift - SHIFT_BW'(1));
      end
      q_sum = q_ext + q_rnd;
      q_shr = q_sum >>> shift;
      q_hi  = q_shr[RW-1:OUT_BW-1];
      q_ovf = !((&q_hi) || !(|q_hi));
      if (q_ovf) begin
         q_sat = q_shr[RW-1] ? {1'b1, {(OUT_BW-1){1'b0}}} : {1'b0, {(OUT_BW-1){1'b1}}};
      end else begin
         q_sat = q_shr[OUT_BW-1:0];
      end
   end

   always_comb begin
      acc_d       = acc_q;
      first_d     = first_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ovf_d       = ovf_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (in_last) begin
            acc_d       = '0;
            first_d     = 1'b1;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = q_sat;
         end else begin
            acc_d   = sum_sat;
            first_d = 1'b0;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + BEAT_CNT_BW'(1);
            end
         end
      end

      // A saturation in the same cycle as clr_flag keeps the flag set.
      if (accept && (acc_ovf || (in_last && q_ovf))) begin
         ovf_d = 1'b1;
      end else if (clr_flag) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         first_q     <= 1'b1;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ovf_q       <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         first_q     <= first_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign beat_cnt  = cnt_q;
   assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed expectations.
module tb_psum_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_data;
   logic        in_last;
   logic [4:0]  shift;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [7:0]  beat_cnt;
   logic        ovf_flag;
   logic        clr_flag;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   psum_accumulator dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .shift     (shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .beat_cnt  (beat_cnt),
      .ovf_flag  (ovf_flag),
      .clr_flag  (clr_flag)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic beat(input int d, input logic last, input int sh);
      in_valid = 1'b1;
      in_data  = 20'(d);
      in_last  = last;
      shift    = 5'(sh);
   endtask

   function automatic int od();
      return int'($signed(out_data));
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; shift = '0;
      out_ready = 1'b1; clr_flag = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", od(), 0);
      chk("rst_beat_cnt", int'(beat_cnt), 0);
      chk("rst_ovf", int'(ovf_flag), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      // Single last beat with rounding shift.
      beat(100, 1'b1, 2); tick();
      in_valid = 1'b0;
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_data", od(), 25);
      chk("t1_cnt", int'(beat_cnt), 0);
      chk("t1_ovf", int'(ovf_flag), 0);
      tick();
      chk("t1_drop", int'(out_valid), 0);

      // Three-beat accumulation.
      beat(1000, 1'b0, 4); tick();
      chk("t2_cnt1", int'(beat_cnt), 1);
      beat(-200, 1'b0, 4); tick();
      chk("t2_cnt2", int'(beat_cnt), 2);
      chk("t2_noval", int'(out_valid), 0);
      beat(50, 1'b1, 4); tick();
      in_valid = 1'b0;
      chk("t2_valid", int'(out_valid), 1);
      chk("t2_data", od(), 53);
      chk("t2_cnt0", int'(beat_cnt), 0);
      tick();
      chk("t2_drop", int'(out_valid), 0);

      // Output saturation and the sticky flag.
      beat(5000, 1'b1, 0); tick();
      in_valid = 1'b0;
      chk("t3_pos_sat", od(), 127);
      chk("t3_ovf_set", int'(ovf_flag), 1);
      clr_flag = 1'b1; tick(); clr_flag = 1'b0;
      chk("t3_ovf_clr", int'(ovf_flag), 0);
      beat(-5000, 1'b1, 0); tick();
      in_valid = 1'b0;
      chk("t3_neg_sat", od(), -128);
      chk("t3_ovf_set2", int'(ovf_flag), 1);
      clr_flag = 1'b1; tick(); clr_flag = 1'b0;
      beat(-7, 1'b1, 1); tick();
      in_valid = 1'b0;
      chk("t3_neg_round", od(), -3);
      chk("t3_ovf_clear", int'(ovf_flag), 0);
      // Set and clear in the same cycle: set wins.
      beat(5000, 1'b1, 0); clr_flag = 1'b1; tick();
      in_valid = 1'b0; clr_flag = 1'b0;
      chk("t3_set_wins", int'(ovf_flag), 1);
      clr_flag = 1'b1; tick(); clr_flag = 1'b0;

      // Backpressure: pending result blocks input.
      out_ready = 1'b0;
      beat(33, 1'b1, 0); tick();
      chk("t4_valid", int'(out_valid), 1);
      chk("t4_data", od(), 33);
      beat(11, 1'b0, 0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_in_ready", int'(in_ready), 0);
         tick();
         chk("t4_stable", od(), 33);
         chk("t4_hold_cnt", int'(beat_cnt), 0);
      end
      out_ready = 1'b1;
      #1;
      chk("t4_ready_up", int'(in_ready), 1);
      tick();
      chk("t4_accept_cnt", int'(beat_cnt), 1);
      chk("t4_handshake", int'(out_valid), 0);
      beat(0, 1'b1, 0); tick();
      in_valid = 1'b0;
      chk("t4_result", od(), 11);
      tick();

      // Back-to-back last beats.
      beat(10, 1'b1, 0); tick();
      chk("t5_v1", int'(out_valid), 1);
      chk("t5_d1", od(), 10);
      beat(20, 1'b1, 0); tick();
      in_valid = 1'b0;
      chk("t5_v2", int'(out_valid), 1);
      chk("t5_d2", od(), 20);
      tick();
      chk("t5_drop", int'(out_valid), 0);

      // Reset mid-accumulation restores the first-beat rule.
      beat(300, 1'b0, 0); tick();
      beat(400, 1'b0, 0); tick();
      chk("t6_cnt2", int'(beat_cnt), 2);
      in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
      chk("t6_rst_cnt", int'(beat_cnt), 0);
      beat(7, 1'b1, 0); tick();
      in_valid = 1'b0;
      chk("t6_data", od(), 7);
      tick();

      // Beat counter saturates; accumulator saturates and flags.
      beat(524287, 1'b0, 0);
      for (int i = 0; i < 260; i++) tick();
      chk("t7_cnt_sat", int'(beat_cnt), 255);
      chk("t7_acc_ovf", int'(ovf_flag), 1);
      beat(0, 1'b1, 16); tick();
      in_valid = 1'b0;
      chk("t7_acc_max_q", od(), 127);
      chk("t7_cnt_clr", int'(beat_cnt), 0);
      clr_flag = 1'b1; tick(); clr_flag = 1'b0;

      // Shifts at or beyond the accumulator width.
      beat(-1, 1'b1, 31); tick();
      in_valid = 1'b0;
      chk("t8_big_shift_neg", od(), 0);
      beat(-524288, 1'b1, 24); tick();
      in_valid = 1'b0;
      chk("t8_shift24", od(), 0);
      chk("t8_no_ovf", int'(ovf_flag), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
